// File: rtl/trig_lut_fetch.sv
`default_nettype none
// ============================================================================
// Module   : trig_lut_fetch
// Purpose  : Produces the sinRead/cosRead trig operands for the vector ALU
//            lane. It reads a single-port, quarter-wave sine ROM twice, once
//            for the sin entry and once for the cos entry. It then applies
//            quadrant folding and sign correction, and presents registered
//            two's-complement results together with a one-cycle valid pulse.
// Ports    : clk      - clock, rising edge
//            rst      - synchronous active-high reset
//            start    - request, sampled only while busy=0
//            angle    - {quadrant[1:0], k[ADDR_W-1:0]}; full circle = 4*M
//            busy     - high while a request is in flight
//            valid    - one-cycle pulse when sinRead/cosRead update
//            sinRead  - folded sine result, held between updates
//            cosRead  - folded cosine result, held between updates
//            rom_en   - ROM read enable
//            rom_addr - ROM address, holds its last value while rom_en=0
//            rom_data - ROM word, valid the cycle after the rom_en edge
// Revision : 1.0 - initial release
// ============================================================================
module trig_lut_fetch #(
  parameter int              N      = 24,
  parameter int              ADDR_W = 8,
  parameter logic [N-1:0]    ONE    = 24'h010000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ADDR_W+1:0]   angle,
  output logic                busy,
  output logic                valid,
  output logic [N-1:0]        sinRead,
  output logic [N-1:0]        cosRead,
  output logic                rom_en,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [N-1:0]        rom_data
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RD_SIN = 2'd1,
    S_RD_COS = 2'd2,
    S_FIN    = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W+1:0]   angle_q, angle_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                en_q, en_d;
  logic [N-1:0]        sin_tmp_q, sin_tmp_d;
  logic [N-1:0]        sin_q, sin_d;
  logic [N-1:0]        cos_q, cos_d;
  logic                valid_q, valid_d;

  // Fields of the incoming angle (used at acceptance) and of the latched one.
  logic [1:0]          quad_in, quad_q;
  logic [ADDR_W-1:0]   k_in, k_q;
  logic [ADDR_W-1:0]   k_in_mir, k_q_mir;
  logic                k_q_zero;

  assign quad_in  = angle[ADDR_W+1:ADDR_W];
  assign k_in     = angle[ADDR_W-1:0];
  assign quad_q   = angle_q[ADDR_W+1:ADDR_W];
  assign k_q      = angle_q[ADDR_W-1:0];
  // M-k truncated to ADDR_W bits equals -k modulo M.
  assign k_in_mir = -k_in;
  assign k_q_mir  = -k_q;
  assign k_q_zero = (k_q == '0);

  // A mirror read with k=0 targets T[M], which is not in the table, so the
  // value +1.0 is substituted for it. The result is then negated if the
  // quadrant requires it. Two's-complement negation maps 0 to 0.
  function automatic logic [N-1:0] fold(input logic [N-1:0] data,
                                        input logic         mirror,
                                        input logic         kzero,
                                        input logic         negate);
    logic [N-1:0] mag;
    mag = (mirror && kzero) ? ONE : data;
    return negate ? -mag : mag;
  endfunction

  // sin reads the mirror entry in the odd quadrants (q1, q3) and is negative
  // in the lower half-plane (q2, q3). cos reads the mirror entry in the even
  // quadrants (q0, q2) and is negative in q1 and q2.
  always_comb begin
    state_d   = state_q;
    angle_d   = angle_q;
    addr_d    = addr_q;
    en_d      = 1'b0;
    sin_tmp_d = sin_tmp_q;
    sin_d     = sin_q;
    cos_d     = cos_q;
    valid_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          angle_d = angle;
          addr_d  = quad_in[0] ? k_in_mir : k_in;
          en_d    = 1'b1;
          state_d = S_RD_SIN;
        end
      end
      S_RD_SIN: begin
        addr_d  = quad_q[0] ? k_q : k_q_mir;
        en_d    = 1'b1;
        state_d = S_RD_COS;
      end
      S_RD_COS: begin
        sin_tmp_d = fold(rom_data, quad_q[0], k_q_zero, quad_q[1]);
        state_d   = S_FIN;
      end
      S_FIN: begin
        cos_d   = fold(rom_data, ~quad_q[0], k_q_zero, quad_q[1] ^ quad_q[0]);
        sin_d   = sin_tmp_q;
        valid_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      angle_q   <= '0;
      addr_q    <= '0;
      en_q      <= 1'b0;
      sin_tmp_q <= '0;
      sin_q     <= '0;
      cos_q     <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      angle_q   <= angle_d;
      addr_q    <= addr_d;
      en_q      <= en_d;
      sin_tmp_q <= sin_tmp_d;
      sin_q     <= sin_d;
      cos_q     <= cos_d;
      valid_q   <= valid_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign valid    = valid_q;
  assign sinRead  = sin_q;
  assign cosRead  = cos_q;
  assign rom_en   = en_q;
  assign rom_addr = addr_q;

endmodule
`default_nettype wire

// File: tb/tb_trig_lut_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_trig_lut_fetch
// Purpose  : Directed self-checking bench for trig_lut_fetch. The ROM model
//            returns T[k] = 16*k. While the ROM is not enabled, it drives a
//            junk word onto rom_data.
// Revision : 1.0 - initial release
// ============================================================================
module tb_trig_lut_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [9:0]  angle = '0;
  logic        busy, valid, rom_en;
  logic [23:0] sinRead, cosRead;
  logic [7:0]  rom_addr;
  logic [23:0] rom_data = '0;

  int n_checks = 0;
  int n_fail   = 0;

  trig_lut_fetch #(.N(24), .ADDR_W(8), .ONE(24'h010000)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .angle    (angle),
    .busy     (busy),
    .valid    (valid),
    .sinRead  (sinRead),
    .cosRead  (cosRead),
    .rom_en   (rom_en),
    .rom_addr (rom_addr),
    .rom_data (rom_data)
  );

  always #5 clk = ~clk;

  // Synchronous ROM: T[k] = 16*k. A junk word appears when the ROM is not read.
  always @(posedge clk) begin
    if (rom_en) rom_data <= {12'h000, rom_addr, 4'h0};
    else        rom_data <= 24'hA5C3E1;
  end

  // Issues one request from IDLE. Returns the two ROM addresses and the
  // latency in edges from the accept edge to valid (10 on timeout). Also
  // returns the outputs seen in the valid cycle. Performs no checking.
  task automatic run_request(input logic [9:0] a, output logic [7:0] sa,
                             output logic [7:0] ca, output int lat,
                             output logic [23:0] s, output logic [23:0] c);
    angle = a;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    angle = ~a;
    sa  = rom_addr;
    ca  = '0;
    lat = 0;
    while (valid !== 1'b1 && lat < 10) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) ca = rom_addr;
    end
    s = sinRead;
    c = cosRead;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", valid); end
    n_checks++; if (rom_en !== 1'b0) begin n_fail++; $display("FAIL reset_rom_en got %b want 0", rom_en); end
    n_checks++; if (rom_addr !== 8'h00) begin n_fail++; $display("FAIL reset_rom_addr got %h want 00", rom_addr); end
    n_checks++; if (sinRead !== 24'h0) begin n_fail++; $display("FAIL reset_sin got %h want 000000", sinRead); end
    n_checks++; if (cosRead !== 24'h0) begin n_fail++; $display("FAIL reset_cos got %h want 000000", cosRead); end
  endtask

  task automatic test_fold();
    logic [9:0]  va [4] = '{10'h000, 10'h100, 10'h240, 10'h3C0};
    logic [7:0]  vsa[4] = '{8'h00, 8'h00, 8'h40, 8'h40};
    logic [7:0]  vca[4] = '{8'h00, 8'h00, 8'hC0, 8'hC0};
    logic [23:0] vs [4] = '{24'h000000, 24'h010000, 24'hFFFC00, 24'hFFFC00};
    logic [23:0] vc [4] = '{24'h010000, 24'h000000, 24'hFFF400, 24'h000C00};
    logic [7:0]  sa, ca;
    logic [23:0] s, c;
    int          lat;
    for (int i = 0; i < 4; i++) begin
      run_request(va[i], sa, ca, lat, s, c);
      n_checks++; if (sa !== vsa[i]) begin n_fail++; $display("FAIL fold%0d_sin_addr got %h want %h", i, sa, vsa[i]); end
      n_checks++; if (ca !== vca[i]) begin n_fail++; $display("FAIL fold%0d_cos_addr got %h want %h", i, ca, vca[i]); end
      n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL fold%0d_latency got %0d want 3", i, lat); end
      n_checks++; if (s !== vs[i]) begin n_fail++; $display("FAIL fold%0d_sin got %h want %h", i, s, vs[i]); end
      n_checks++; if (c !== vc[i]) begin n_fail++; $display("FAIL fold%0d_cos got %h want %h", i, c, vc[i]); end
      @(posedge clk); #1;
      n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL fold%0d_pulse got %b want 0", i, valid); end
      n_checks++; if (sinRead !== vs[i]) begin n_fail++; $display("FAIL fold%0d_hold got %h want %h", i, sinRead, vs[i]); end
    end
  endtask

  // A request for angle 0x010 reads T[0x10]=0x100 for sin and T[0xF0]=0xF00
  // for cos. start stays high through the whole busy period.
  task automatic test_busy_ignore();
    int          nvalid = 0;
    logic [23:0] s = '0, c = '0;
    angle = 10'h010;
    start = 1'b1;
    @(posedge clk); #1;
    angle = 10'h3FF;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (valid === 1'b1) begin nvalid++; s = sinRead; c = cosRead; end
    end
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (valid === 1'b1) nvalid++;
    end
    n_checks++; if (nvalid !== 1) begin n_fail++; $display("FAIL busy_valid_count got %0d want 1", nvalid); end
    n_checks++; if (s !== 24'h000100) begin n_fail++; $display("FAIL busy_sin got %h want 000100", s); end
    n_checks++; if (c !== 24'h000F00) begin n_fail++; $display("FAIL busy_cos got %h want 000F00", c); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_idle got %b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  sa, ca;
    logic [23:0] s, c;
    int          lat, gap;
    run_request(10'h240, sa, ca, lat, s, c);
    angle = 10'h010;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    angle = 10'h000;
    gap = 1;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept got %b want 1", busy); end
    n_checks++; if (sinRead !== 24'hFFFC00) begin n_fail++; $display("FAIL b2b_hold_sin got %h want FFFC00", sinRead); end
    while (valid !== 1'b1 && gap < 10) begin
      @(posedge clk); #1;
      gap++;
    end
    n_checks++; if (gap !== 4) begin n_fail++; $display("FAIL b2b_gap got %0d want 4", gap); end
    n_checks++; if (sinRead !== 24'h000100) begin n_fail++; $display("FAIL b2b_sin got %h want 000100", sinRead); end
    n_checks++; if (cosRead !== 24'h000F00) begin n_fail++; $display("FAIL b2b_cos got %h want 000F00", cosRead); end
  endtask

  task automatic test_reset_mid();
    int nvalid = 0;
    angle = 10'h100;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got %b want 0", busy); end
    n_checks++; if (rom_en !== 1'b0) begin n_fail++; $display("FAIL rstmid_rom_en got %b want 0", rom_en); end
    n_checks++; if (rom_addr !== 8'h00) begin n_fail++; $display("FAIL rstmid_rom_addr got %h want 00", rom_addr); end
    n_checks++; if (sinRead !== 24'h0) begin n_fail++; $display("FAIL rstmid_sin got %h want 000000", sinRead); end
    n_checks++; if (cosRead !== 24'h0) begin n_fail++; $display("FAIL rstmid_cos got %h want 000000", cosRead); end
    if (valid === 1'b1) nvalid++;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (valid === 1'b1) nvalid++;
    end
    n_checks++; if (nvalid !== 0) begin n_fail++; $display("FAIL rstmid_no_valid got %0d want 0", nvalid); end
  endtask

  initial begin
    test_reset();
    test_fold();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/trig_lut_fetch.md
Name: trig_lut_fetch

Overview:
- Upstream feeder for the vector ALU lane's trig operands: produces the sinRead/cosRead words that the lane ALU returns for select 4'b1011 (sin) and 4'b1100 (cos).
- Takes an angle index and reads a single-port, quarter-wave, synchronous sine ROM twice: once for the sin entry, once for the cos entry.
- Applies quadrant folding and sign correction, then presents registered N-bit two's-complement sin/cos results with a one-cycle valid pulse.

Parameters:
- N, 24, data width of ROM words and of sinRead/cosRead (two's complement fixed point).
- ADDR_W, 8, quarter-table address width; table depth M = 2^ADDR_W.
- ONE, 24'h010000, fixed-point value of +1.0, substituted for the absent entry T[M]; must fit in N bits as a positive value.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  request; sampled only when busy=0.
- angle  input  ADDR_W+2  angle index; [ADDR_W+1:ADDR_W] = quadrant q, [ADDR_W-1:0] = k; full circle = 4*M.
- busy  output  1  high while a request is in flight.
- valid  output  1  one-cycle pulse when sinRead/cosRead update.
- sinRead  output  N  folded sine result, registered, held between updates.
- cosRead  output  N  folded cosine result, registered, held between updates.
- rom_en  output  1  ROM read enable.
- rom_addr  output  ADDR_W  ROM address.
- rom_data  input  N  ROM word T[addr]; valid the cycle after the rom_en edge.

Behaviour:
- Table: T[k] = sin(k*(pi/2)/M), k = 0..M-1.
- Mirror index: M-k, truncated to ADDR_W bits. A mirror read with k=0 uses ONE instead of rom_data. The ROM is still read that cycle, so timing is unchanged.
- sin folding by q:
  - q0: +T[k]
  - q1: +T[M-k]
  - q2: -T[k]
  - q3: -T[M-k]
- cos folding by q:
  - q0: +T[M-k]
  - q1: -T[k]
  - q2: -T[M-k]
  - q3: +T[k]
- Negation is N-bit two's complement; -0 = 0.
- FSM states: IDLE, RD_SIN, RD_COS, FIN.
  - IDLE: busy=0, rom_en=0. When start=1 at edge E0: latch angle, go to RD_SIN.
  - RD_SIN: busy=1, rom_en=1, rom_addr = sin address. Go to RD_COS.
  - RD_COS: busy=1, rom_en=1, rom_addr = cos address. At edge E2, capture the corrected sin value into an internal register. Go to FIN.
  - FIN: busy=1, rom_en=0. At edge E3, capture the corrected cos value; update sinRead and cosRead together; assert valid for the following cycle. Go to IDLE.
- Latency: valid is high in the 3rd cycle after the start edge. Throughput is one request per 4 cycles.
- start while busy=1: ignored, no queuing.
- start in the cycle valid=1: accepted normally, since the state is IDLE. Outputs hold until the new result lands.
- Angle is latched at acceptance. Later angle changes have no effect on the request in flight.
- rom_addr holds its last value when rom_en=0.
- Reset, including mid-operation:
  - state to IDLE; busy, valid, rom_en = 0; rom_addr = 0; sinRead = cosRead = 0; internal sin register = 0.
  - An aborted request never produces valid.
- rom_data is ignored except in the capture cycles.

Test Plan:
- Bench ROM model T[k] = 16*k, ADDR_W=8, ONE=0x010000. Reset for 2 cycles, then hold -> busy=0, valid=0, rom_en=0, rom_addr=0, sinRead=cosRead=0.
- start with angle=0x000 -> rom_addr 0x00 then 0x00. Valid at start+3 with sinRead=0x000000, cosRead=0x010000 (ONE substitution).
- angle=0x100 (q1, k0) -> sinRead=0x010000, cosRead=0x000000.
- angle=0x240 (q2, k=0x40) -> rom_addr 0x40 then 0xC0; sinRead=0xFFFC00, cosRead=0xFFF400.
- angle=0x3C0 (q3, k=0xC0) -> sinRead=0xFFFC00, cosRead=0x000C00.
- Boundary and control cases:
  - start pulses during busy -> ignored, exactly one valid.
  - Back-to-back start in the valid cycle -> second valid 4 cycles after the first.
  - rst asserted in RD_COS -> no valid; outputs = 0 the next cycle.
